// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 1-bit/cycle multiply/divide sequencer (signed ops when MULDIV_SIGNED_EN is defined)
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_result;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_dz;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_dz_res;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sh;
  logic [WIDTH:0]       w_sub;
  logic [2*WIDTH-1:0]   w_nx;
  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH-1:0]     w_res;
  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_dz     = op[1] & (b == '0);
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_dz_res = op[0] ? a : '1;
  // one shift-add (multiply) or restore-subtract (divide) step on the shared product/remainder register
  always_comb begin
    w_add = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_sh  = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    w_sub = w_sh - {1'b0, r_opnd};
    w_nx  = r_op[1] ? {(w_sub[WIDTH] ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0]), r_prod[WIDTH-2:0], ~w_sub[WIDTH]}
                    : {w_add, r_prod[WIDTH-1:1]};
    w_hi  = w_nx[2*WIDTH-1:WIDTH];
    w_lo  = w_nx[WIDTH-1:0];
  end
`ifdef MULDIV_SIGNED_EN
  logic               r_nq;
  logic               r_nr;
  logic [2*WIDTH-1:0] w_prod_s;
  assign w_a_mag = (op[2] & a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (op[2] & b[WIDTH-1]) ? -b : b;
  // result sign flags captured with the operands: quotient/product sign and remainder (dividend) sign
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_nq <= 1'b0;
      r_nr <= 1'b0;
    end else if (w_accept) begin
      r_nq <= op[2] & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_nr <= op[2] & a[WIDTH-1];
    end
  // sign correction applied to the final iteration's output as DONE is entered
  always_comb begin
    w_prod_s = r_nq ? -w_nx : w_nx;
    w_res    = r_op[1] ? (r_op[0] ? (r_nr ? -w_hi : w_hi) : (r_nq ? -w_lo : w_lo))
                       : (r_op[0] ? w_prod_s[2*WIDTH-1:WIDTH] : w_prod_s[WIDTH-1:0]);
  end
`else
  logic w_unused_op2;
  assign w_unused_op2 = op[2];
  assign w_a_mag      = a;
  assign w_b_mag      = b;
  assign w_res        = r_op[0] ? w_hi : w_lo;
`endif
  // sequencer: accept, iterate WIDTH times, present the result for one cycle; flush aborts anywhere
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else
        case (r_state)
          S_IDLE:
            if (start) begin
              r_op   <= op[1:0];
              r_cnt  <= '0;
              r_opnd <= op[1] ? w_b_mag : w_a_mag;
              r_prod <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
              r_busy <= 1'b1;
              if (w_dz) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_result <= w_dz_res;
              end else
                r_state <= S_CALC;
            end
          S_CALC: begin
            r_prod <= w_nx;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_res;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
    end
  assign stall  = w_accept | (r_state == S_CALC);
  assign busy   = r_busy;
  assign done   = r_done & ~flush;
  assign result = r_result;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed-vector self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res;
  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int lat, input logic [31:0] exp);
    int n;
    bit seen;
    bit stall_ok;
    @(posedge clk); #1 start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    check({tag, " stall@accept"}, 32'(stall), 32'd1);
    @(posedge clk); #1 start = 1'b0; a = '0; b = '0;
    n = 0; seen = 0; stall_ok = 1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (!stall) stall_ok = 0;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall@done"}, {stall_ok, stall}, 2'b10);
    @(negedge clk);
    check({tag, " done/busy after"}, {done, busy}, 2'b00);
    last_res = exp;
  endtask
  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("reset outs", {busy, stall, done}, 3'b000);
    check("reset result", result, 32'h0);
    rst_n = 1'b1;
    run("MUL", 3'b000, 32'h0001_2345, 32'h0000_1000, 33, 32'h1234_5000);
    run("MULHU ones", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run("MUL ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001);
    run("MULHU msb", 3'b001, 32'h8000_0000, 32'h0000_0004, 33, 32'h0000_0002);
    run("DIVU", 3'b010, 32'd100, 32'd7, 33, 32'd14);
    run("REMU", 3'b011, 32'd100, 32'd7, 33, 32'd2);
    run("DIVU big", 3'b010, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF);
    run("REMU big", 3'b011, 32'hFFFF_FFFF, 32'h10, 33, 32'h0000_000F);
    run("DIVU by0", 3'b010, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run("REMU by0", 3'b011, 32'd5, 32'd0, 1, 32'd5);
    // flush in the 10th CALC cycle, with a stray start in CALC cycle 3
    @(posedge clk); #1 start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    @(negedge clk);
    check("calc stall/busy", {stall, busy}, 2'b11);
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush cycle done", 32'(done), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("after flush", {busy, stall}, 2'b00);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done | busy) seen = 1;
    end
    check("no done after flush", 32'(seen), 32'd0);
    check("result kept", result, last_res);
    // flush while in DONE suppresses the pulse
    @(posedge clk); #1 start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd0;
    @(posedge clk); #1 start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush in DONE", {done, busy}, 2'b01);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("idle after DONE flush", {done, busy}, 2'b00);
    // flush wins over start in IDLE
    @(posedge clk); #1 start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(negedge clk);
    check("flush>start stall", 32'(stall), 32'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush>start busy", 32'(busy), 32'd0);
    // asynchronous reset in the middle of CALC
    @(posedge clk); #1 start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset midcalc outs", {busy, stall, done}, 3'b000);
    check("reset midcalc result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run("MUL post-reset", 3'b000, 32'd5, 32'd6, 33, 32'd30);
`ifdef MULDIV_SIGNED_EN
    run("DIV -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run("REM -7/2", 3'b111, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run("DIV ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    run("REM ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0);
    run("MULH -2*3", 3'b101, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF);
    run("MUL s -2*3", 3'b100, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFA);
    run("DIV s by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF);
    run("REM s by0", 3'b111, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB);
`else
    run("DIVU op2 ignored", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC);
    run("MULHU op2 ignored", 3'b101, 32'hFFFF_FFFE, 32'd3, 33, 32'h0000_0002);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the EX stage of the pipelined RV32 core. It accepts one operation, runs a 1-bit-per-cycle shift-add multiply or restoring divide, and holds `stall` so the pipeline freezes upstream stages. It delivers the result with a one-cycle `done` pulse. It sits beside the main ALU, and the EX-stage result mux selects it when `done`=1.

Parameters:
- WIDTH, 32, operand/result width in bits (even, ≥4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new operation; sampled only in IDLE.
- op, input, 3, [1:0]: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU; [2] signed select (see Optional Feature).
- a, input, WIDTH, operand A (multiplicand/dividend); captured on accept.
- b, input, WIDTH, operand B (multiplier/divisor); captured on accept.
- flush, input, 1, abort the in-flight operation (branch/exception flush).
- busy, output, 1, high while in CALC or DONE.
- stall, output, 1, pipeline hold request.
- done, output, 1, one-cycle result-valid pulse.
- result, output, WIDTH, selected result word; held until the next accept.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, stall=0, done=0, result=0; counter and internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 → accept: latch a, b, op; counter=0.
  - Divide op with b=0 → DONE next cycle (no CALC).
  - Otherwise → CALC.
- CALC:
  - One iteration per cycle; counter increments.
  - After WIDTH iterations (counter==WIDTH-1 on the edge), go to DONE.
- DONE:
  - done=1 and result valid for exactly one cycle.
  - Always return to IDLE next cycle; start is not sampled in DONE.
- Latency: accept at edge T → done high in cycle T+WIDTH+1 (WIDTH=32: 33 cycles). Divide-by-zero: done in cycle T+1.
- stall, combinational: (IDLE & start & ~flush) | CALC. Deasserted in DONE so the instruction advances that cycle.
- busy, registered: 1 in CALC and DONE.
- Multiply:
  - 2*WIDTH-bit product register; add multiplicand when the current multiplier LSB is 1, then shift right.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- Divide:
  - Restoring: shift remainder left with the next dividend bit; subtract divisor when remainder ≥ divisor, setting the quotient bit.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: DIVU result = all ones; REMU result = a. done asserts normally.
- flush: in any state, forces IDLE on the next edge.
  - done is suppressed (0) even if the state was DONE; result is not updated.
  - flush has priority over start in IDLE.
- start while busy is ignored; no queueing.
- result updates only on the CALC→DONE or IDLE→DONE transition.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined: op[2]=1 selects signed operation (MULH/DIV/REM).
  - Operands are converted to magnitude on accept; the result sign is fixed in the DONE-entry cycle (latency unchanged).
  - DIV overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1), remainder = 0.
  - Signed divide by zero: quotient = -1, remainder = a.
  - MUL low word is identical for signed and unsigned.
- Undefined: op[2] ignored; all operations unsigned; no sign logic synthesized.

Test Plan:
- Reset mid-CALC (rst_n low at cycle 10) → busy/stall/done/result = 0 immediately; next start accepted normally.
- MUL a=0x0001_2345, b=0x0000_1000, start at T → done only in cycle T+33, result=0x1234_5000; stall high T..T+32 and low at T+33.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF → result=0xFFFF_FFFE; MUL same operands → 0x0000_0001.
- DIVU a=100, b=7 → result=14; REMU → result=2. DIVU a=5, b=0 → done at T+1, result=0xFFFF_FFFF; REMU b=0 → result=5.
- flush at the 10th CALC cycle of DIVU → IDLE next cycle, no done pulse, result keeps its prior value; start during CALC ignored.
- With MULDIV_SIGNED_EN: DIV a=-7, b=2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIV a=0x8000_0000, b=-1 → 0x8000_0000, REM → 0.
